// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes,
// datapath mux select codes and the trap cause.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_BUS     = 2'd2
  } trap_cause_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are covered by the watchdog.
  function automatic logic is_mem_wait(input state_t s);
    return s inside {S_FETCH, S_MEMRD, S_MEMWR};
  endfunction

endpackage

// File: rtl/mips_mc_watchdog.sv
// Saturating memory-wait counter; flags a timeout in the cycle the count would
// reach MEM_TIMEOUT. MEM_TIMEOUT=0 disables the timeout.
module mips_mc_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
  localparam bit WD_EN = (MEM_TIMEOUT > 0);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = WD_EN && inc && (count >= CNT_LAST);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory-wait watchdog and illegal-opcode trap.
// Optional feature macro: MC_BNE_EN (adds bne through the BRANCH state).
module mips_multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            iord,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            branch,
  output logic            branch_ne,
  output logic            illegal_op,
  output logic            bus_err,
  output logic [3:0]      state
);

  localparam logic [OP_W-1:0] OPC_RTYPE = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] OPC_J     = OP_W'(OP_J);
  localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] OPC_ADDI  = OP_W'(OP_ADDI);
  localparam logic [OP_W-1:0] OPC_LW    = OP_W'(OP_LW);
  localparam logic [OP_W-1:0] OPC_SW    = OP_W'(OP_SW);
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OPC_BNE   = OP_W'(OP_BNE);
`endif

  state_t      state_q, state_d;
  trap_cause_t cause_q, cause_d;
  logic        wd_timeout, wd_clear, wd_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

`ifdef MC_BNE_EN
  // Remembers which branch flavour DECODE chose so BRANCH stays a pure state decode.
  logic bne_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bne_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      bne_q <= (op == OPC_BNE);
    end
  end
`endif

  assign wd_inc   = is_mem_wait(state_q) && !mem_ready;
  assign wd_clear = (state_d != state_q) || mem_ready;

  mips_mc_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .inc    (wd_inc),
    .timeout(wd_timeout)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wd_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_DECODE: begin
        if ((op == OPC_LW) || (op == OPC_SW)) state_d = S_MEMADR;
        else if (op == OPC_RTYPE)             state_d = S_EXEC;
        else if (op == OPC_BEQ)               state_d = S_BRANCH;
`ifdef MC_BNE_EN
        else if (op == OPC_BNE)               state_d = S_BRANCH;
`endif
        else if (op == OPC_ADDI)              state_d = S_ADDIEX;
        else if (op == OPC_J)                 state_d = S_JUMP;
        else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEMADR: state_d = (op == OPC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (wd_timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_BUS;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PCSRC_ALU;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
`ifdef MC_BNE_EN
        branch    = !bne_q;
        branch_ne = bne_q;
`else
        branch    = 1'b1;
`endif
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_TRAP: begin
        illegal_op = (cause_q == CAUSE_ILLEGAL);
        bus_err    = (cause_q == CAUSE_BUS);
      end
      default: ;
    endcase
    // Reset forces the state to FETCH immediately; suppress its side effects too.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: table-driven instruction flows
// plus directed sequences for wait states, watchdog timeouts and mid-state reset.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

  localparam int MT = 4;

  typedef logic [17:0] ctrl_t;
  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    ctrl_t      ctrl;
  } vec_t;

  // Field order: pc_write ir_write iord mem_write mem_to_reg reg_dst reg_write
  // alu_src_a | alu_src_b | alu_op | pc_src | branch branch_ne illegal_op bus_err
  localparam ctrl_t C_F1   = 18'b1_1_0_0_0_0_0_0_01_00_00_0_0_0_0;
  localparam ctrl_t C_F0   = 18'b0_0_0_0_0_0_0_0_01_00_00_0_0_0_0;
  localparam ctrl_t C_DEC  = 18'b0_0_0_0_0_0_0_0_11_00_00_0_0_0_0;
  localparam ctrl_t C_MA   = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
  localparam ctrl_t C_MRD  = 18'b0_0_1_0_0_0_0_0_00_00_00_0_0_0_0;
  localparam ctrl_t C_MWB  = 18'b0_0_0_0_1_0_1_0_00_00_00_0_0_0_0;
  localparam ctrl_t C_EX   = 18'b0_0_0_0_0_0_0_1_00_10_00_0_0_0_0;
  localparam ctrl_t C_AWB  = 18'b0_0_0_0_0_1_1_0_00_00_00_0_0_0_0;
  localparam ctrl_t C_BR   = 18'b0_0_0_0_0_0_0_1_00_01_01_1_0_0_0;
  localparam ctrl_t C_AIE  = 18'b0_0_0_0_0_0_0_1_10_00_00_0_0_0_0;
  localparam ctrl_t C_AIW  = 18'b0_0_0_0_0_0_1_0_00_00_00_0_0_0_0;
  localparam ctrl_t C_JMP  = 18'b1_0_0_0_0_0_0_0_00_00_10_0_0_0_0;
  localparam ctrl_t C_TIL  = 18'b0_0_0_0_0_0_0_0_00_00_00_0_0_1_0;
`ifdef MC_BNE_EN
  localparam ctrl_t C_BNE  = 18'b0_0_0_0_0_0_0_1_00_01_01_0_1_0_0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_write, mem_to_reg, reg_dst, reg_write;
  logic       alu_src_a, branch, branch_ne, illegal_op, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  ctrl_t      ctrl_now;

  int compared = 0;
  int mismatched = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mips_multicycle_control #(.OP_W(6), .MEM_TIMEOUT(MT)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .iord      (iord),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst   (reg_dst),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_src    (pc_src),
    .branch    (branch),
    .branch_ne (branch_ne),
    .illegal_op(illegal_op),
    .bus_err   (bus_err),
    .state     (state)
  );

  assign ctrl_now = {pc_write, ir_write, iord, mem_write, mem_to_reg, reg_dst, reg_write,
                     alu_src_a, alu_src_b, alu_op, pc_src, branch, branch_ne,
                     illegal_op, bus_err};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic r, input logic [3:0] s, input ctrl_t c);
    vec_t v;
    v.op = o;
    v.rdy = r;
    v.st = s;
    v.ctrl = c;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [5:0] o, input logic r);
    op = o;
    mem_ready = r;
    @(negedge clk);
  endtask

  // Holds mem_ready low and counts cycles spent before the FSM lands in TRAP.
  task automatic run_to_trap(output int n, output int mw_cycles, output bit wr_seen);
    n = 0;
    mw_cycles = 0;
    wr_seen = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (state == 4'd12) break;
      if (pc_write || ir_write || reg_write) wr_seen = 1'b1;
      if (mem_write) mw_cycles++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n, mw;
    bit wr;

    // Reset behaviour
    #2 reset = 1'b1;
    #1;
    check("reset_state", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("reset_pc_write", 32'(pc_write), 32'd0);
    check("reset_ir_write", 32'(ir_write), 32'd0);
    check("reset_alu_src_b", 32'(alu_src_b), 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_state", 32'(state), 32'd0);

    // lw, no waits
    add(LW, 1'b1, 4'd0, C_F1);  add(LW, 1'b1, 4'd1, C_DEC); add(LW, 1'b1, 4'd2, C_MA);
    add(LW, 1'b1, 4'd3, C_MRD); add(LW, 1'b1, 4'd4, C_MWB);
    // lw with fetch and read waits; mem_ready ignored in DECODE/MEMADR
    add(LW, 1'b0, 4'd0, C_F0);  add(LW, 1'b1, 4'd0, C_F1);  add(LW, 1'b0, 4'd1, C_DEC);
    add(LW, 1'b0, 4'd2, C_MA);  add(LW, 1'b0, 4'd3, C_MRD); add(LW, 1'b0, 4'd3, C_MRD);
    add(LW, 1'b1, 4'd3, C_MRD); add(LW, 1'b1, 4'd4, C_MWB);
    // R-type
    add(RT, 1'b1, 4'd0, C_F1);  add(RT, 1'b1, 4'd1, C_DEC); add(RT, 1'b0, 4'd6, C_EX);
    add(RT, 1'b0, 4'd7, C_AWB);
    // beq
    add(BEQ, 1'b1, 4'd0, C_F1); add(BEQ, 1'b1, 4'd1, C_DEC); add(BEQ, 1'b1, 4'd8, C_BR);
    // addi
    add(ADDI, 1'b1, 4'd0, C_F1); add(ADDI, 1'b1, 4'd1, C_DEC); add(ADDI, 1'b1, 4'd9, C_AIE);
    add(ADDI, 1'b1, 4'd10, C_AIW);
    // j
    add(JMP, 1'b1, 4'd0, C_F1); add(JMP, 1'b1, 4'd1, C_DEC); add(JMP, 1'b1, 4'd11, C_JMP);
    // illegal opcode: one-cycle illegal_op, then back to FETCH
    add(BAD, 1'b1, 4'd0, C_F1); add(BAD, 1'b1, 4'd1, C_DEC); add(BAD, 1'b0, 4'd12, C_TIL);
    // bne
    add(BNE, 1'b1, 4'd0, C_F1); add(BNE, 1'b1, 4'd1, C_DEC);
`ifdef MC_BNE_EN
    add(BNE, 1'b1, 4'd8, C_BNE);
`else
    add(BNE, 1'b1, 4'd12, C_TIL);
`endif
    add(RT, 1'b0, 4'd0, C_F0);

    for (int i = 0; i < vecs.size(); i++) begin
      op = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_now), 32'(vecs[i].ctrl));
      @(negedge clk);
    end

    // sw with mem_ready low for 3 cycles in MEMWR
    step(SW, 1'b1);
    step(SW, 1'b1);
    step(SW, 1'b1);
    mw = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #1;
      if (mem_write) mw++;
      @(negedge clk);
    end
    #1;
    check("sw_wait_mem_write_cycles", 32'(mw), 32'd4);
    check("sw_wait_back_to_fetch", 32'(state), 32'd0);
    check("sw_wait_mem_write_dropped", 32'(mem_write), 32'd0);

    // Watchdog in FETCH
    op = LW;
    run_to_trap(n, mw, wr);
    check("fetch_timeout_cycles", 32'(n), 32'd4);
    check("fetch_timeout_state", 32'(state), 32'd12);
    check("fetch_timeout_no_write", 32'(wr), 32'd0);
    check("fetch_timeout_bus_err", 32'(bus_err), 32'd1);
    check("fetch_timeout_illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk);
    #1;
    check("fetch_timeout_return", 32'(state), 32'd0);
    check("fetch_timeout_bus_err_pulse", 32'(bus_err), 32'd0);

    // Watchdog in MEMWR
    step(SW, 1'b1);
    step(SW, 1'b1);
    step(SW, 1'b1);
    run_to_trap(n, mw, wr);
    check("memwr_timeout_cycles", 32'(n), 32'd4);
    check("memwr_timeout_mem_write_cycles", 32'(mw), 32'd4);
    check("memwr_timeout_state", 32'(state), 32'd12);
    check("memwr_timeout_mem_write_drop", 32'(mem_write), 32'd0);
    check("memwr_timeout_bus_err", 32'(bus_err), 32'd1);
    @(negedge clk);

    // Reset mid-MEMWR after two wait cycles have been counted
    step(SW, 1'b1);
    step(SW, 1'b1);
    step(SW, 1'b1);
    step(SW, 1'b0);
    step(SW, 1'b0);
    #1;
    check("pre_reset_mem_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_mem_write", 32'(mem_write), 32'd0);
    check("mid_reset_state", 32'(state), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("mid_reset_pc_write", 32'(pc_write), 32'd0);
    check("mid_reset_ir_write", 32'(ir_write), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_reset_state", 32'(state), 32'd0);
    run_to_trap(n, mw, wr);
    check("after_reset_counter_cleared", 32'(n), 32'd4);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("final_state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
